// File: rtl/alu_arbiter.sv
// Purpose     : round-robin share of one combinational 32-bit ALU between two requesters,
//               with the ALU result/flags captured in a one-entry response buffer.
// Latency     : 1 cycle from acceptance (reqX_valid && reqX_ready) to rsp_valid.
// Backpressure: rsp_valid/rsp_ready; while the buffer is full and not drained no requester is ready.
//
// Ports:
//   clk, reset                       rising-edge clock, synchronous active-high reset
//   req{0,1}_valid/_ready            requester handshake (ready may depend on valid)
//   req{0,1}_srca/_srcb/_ctrl        requester operands and ALUControl (00 add, 01 sub, 10 and, 11 or)
//   alu_srca/alu_srcb/alu_ctrl       drive to the shared ALU (all zero when nobody is granted)
//   alu_result, alu_{zero,negative,overflow,carry}   combinational ALU outputs
//   rsp_valid/rsp_ready              response handshake
//   rsp_id, rsp_result, rsp_flags    issuing requester, result, flags as {N,Z,C,V}

module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_srca,
    input  logic [WIDTH-1:0] req0_srcb,
    input  logic [1:0]       req0_ctrl,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_srca,
    input  logic [WIDTH-1:0] req1_srcb,
    input  logic [1:0]       req1_ctrl,

    output logic [WIDTH-1:0] alu_srca,
    output logic [WIDTH-1:0] alu_srcb,
    output logic [1:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_negative,
    input  logic             alu_overflow,
    input  logic             alu_carry,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rsp_state_t;

    rsp_state_t       r_state;
    logic             r_pref;       // requester preferred when both are valid
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_result;
    logic [3:0]       r_rsp_flags;

    logic             w_can_accept;
    logic             w_grant_vld;
    logic             w_grant_id;
    logic             w_accept;

    // The buffer can take a new entry when empty, or when the held entry
    // leaves on this same edge (gives 1 op/cycle back-to-back).
    assign w_can_accept = (r_state == ST_EMPTY) || rsp_ready;

    // Grant: a lone valid requester wins; on contention the pointer decides.
    assign w_grant_vld = req0_valid || req1_valid;
    assign w_grant_id  = (req0_valid && req1_valid) ? r_pref : req1_valid;

    // Reset gates acceptance so nothing is handed off while the buffer is
    // being cleared.
    assign w_accept   = w_grant_vld && w_can_accept && !reset;
    assign req0_ready = w_accept && (w_grant_id == 1'b0);
    assign req1_ready = w_accept && (w_grant_id == 1'b1);

    // ALU operand mux; with no grant the ALU sees add 0+0, which is harmless
    // because nothing captures it.
    always_comb begin
        alu_srca = '0;
        alu_srcb = '0;
        alu_ctrl = 2'b00;
        if (w_grant_vld) begin
            if (w_grant_id) begin
                alu_srca = req1_srca;
                alu_srcb = req1_srcb;
                alu_ctrl = req1_ctrl;
            end else begin
                alu_srca = req0_srca;
                alu_srcb = req0_srcb;
                alu_ctrl = req0_ctrl;
            end
        end
    end

    // Response buffer state machine plus round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_EMPTY;
            r_pref       <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_flags  <= 4'b0000;
        end else begin
            if (w_accept) begin
                // Covers both EMPTY->FULL and FULL->FULL with replacement.
                r_state      <= ST_FULL;
                r_rsp_id     <= w_grant_id;
                r_rsp_result <= alu_result;
                r_rsp_flags  <= {alu_negative, alu_zero, alu_carry, alu_overflow};
                // The requester just served drops to second place.
                r_pref       <= ~w_grant_id;
            end else if ((r_state == ST_FULL) && rsp_ready) begin
                r_state <= ST_EMPTY;
            end
        end
    end

    assign rsp_valid  = (r_state == ST_FULL);
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;

endmodule
